// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit feeder: byte width and the
// launch-controller state encoding.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_BUSY = 2'b10,
    ST_GAP  = 2'b11
  } state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO for the UART feeder. Occupancy flags are registered
// and reflect the state before each edge, so a write and a pop in the same
// cycle are both judged against the old flags. Writes while full are dropped
// and reported through ovf_evt; flush clears everything and swallows a
// same-cycle write silently.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf_evt
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [ADDR_W-1:0] wptr_r;
  logic [ADDR_W-1:0] rptr_r;
  logic [ADDR_W:0]   count_r;
  logic              full_r;
  logic              empty_r;
  logic              wr_ok_s;
  logic              pop_ok_s;
  logic              ovf_evt_s;
  logic [ADDR_W:0]   count_nxt_s;

  // Qualify writes and pops against the pre-edge flags; flush masks both
  always_comb begin
    wr_ok_s   = 1'b0;
    pop_ok_s  = 1'b0;
    ovf_evt_s = 1'b0;
    if (flush) begin
      wr_ok_s   = 1'b0;
      pop_ok_s  = 1'b0;
      ovf_evt_s = 1'b0;
    end else begin
      wr_ok_s   = wr_en && !full_r;
      pop_ok_s  = pop && !empty_r;
      ovf_evt_s = wr_en && full_r;
    end
  end

  // Next occupancy: a simultaneous write and pop leave the count unchanged
  always_comb begin
    count_nxt_s = count_r;
    if (flush) begin
      count_nxt_s = '0;
    end else begin
      case ({wr_ok_s, pop_ok_s})
        2'b10:   count_nxt_s = count_r + (ADDR_W + 1)'(1);
        2'b01:   count_nxt_s = count_r - (ADDR_W + 1)'(1);
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Byte storage, written only on accepted writes
  always_ff @(posedge clk_50M) begin
    if (wr_ok_s) begin
      mem_r[wptr_r] <= wr_data;
    end
  end

  // Pointers, occupancy and registered full/empty flags
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
    end else begin
      if (flush) begin
        wptr_r <= '0;
        rptr_r <= '0;
      end else begin
        if (wr_ok_s) begin
          wptr_r <= wptr_r + ADDR_W'(1);
        end
        if (pop_ok_s) begin
          rptr_r <= rptr_r + ADDR_W'(1);
        end
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == (ADDR_W + 1)'(DEPTH));
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign rd_data = mem_r[rptr_r];
  assign full    = full_r;
  assign empty   = empty_r;
  assign count   = count_r;
  assign ovf_evt = ovf_evt_s;

endmodule

// File: rtl/uart_tx_feeder.sv
// Launch controller in front of the UART transmitter. Buffers host bytes in
// uart_sync_fifo, presents one byte at a time on a level request, waits for
// the transmitter's frame to finish and enforces an idle gap between frames.
// A request the transmitter never acknowledges is abandoned after TIMEOUT
// cycles. Overflow and timeout are reported as sticky flags.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int DATA_W     = uart_pkg::DATA_W,
  parameter int TIMEOUT    = 1023,
  parameter int GAP_CYCLES = 4
) (
  input  logic              clk_50M,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              drain_en,
  input  logic              clr_err,
  input  logic              tx_busy,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  output logic              overflow,
  output logic              timeout_err
);

  localparam int TIMER_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST = TIMER_W'(GAP_CYCLES - 1);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [TIMER_W-1:0]  timer_r;
  logic [TIMER_W-1:0]  timer_nxt_s;
  logic                tx_req_r;
  logic                tx_req_nxt_s;
  logic [DATA_W-1:0]   tx_data_r;
  logic                overflow_r;
  logic                timeout_err_r;
  logic                pop_s;
  logic                to_evt_s;
  logic                ovf_evt_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                full_s;
  logic                empty_s;
  logic [ADDR_W:0]     count_s;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk_50M (clk_50M),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .pop     (pop_s),
    .flush   (flush),
    .rd_data (rd_data_s),
    .full    (full_s),
    .empty   (empty_s),
    .count   (count_s),
    .ovf_evt (ovf_evt_s)
  );

  // Launch FSM: next state, timer, request level, pop and timeout event
  always_comb begin
    state_nxt_s  = state_r;
    timer_nxt_s  = timer_r;
    tx_req_nxt_s = tx_req_r;
    pop_s        = 1'b0;
    to_evt_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (drain_en && !empty_s) begin
          pop_s        = 1'b1;
          tx_req_nxt_s = 1'b1;
          timer_nxt_s  = '0;
          state_nxt_s  = ST_REQ;
        end else begin
          tx_req_nxt_s = 1'b0;
        end
      end
      ST_REQ: begin
        if (tx_busy) begin
          tx_req_nxt_s = 1'b0;
          timer_nxt_s  = '0;
          state_nxt_s  = ST_BUSY;
        end else if (timer_r == TO_LAST) begin
          // Transmitter never took the byte: drop it and move on
          tx_req_nxt_s = 1'b0;
          to_evt_s     = 1'b1;
          timer_nxt_s  = '0;
          state_nxt_s  = ST_GAP;
        end else begin
          timer_nxt_s  = timer_r + TIMER_W'(1);
        end
      end
      ST_BUSY: begin
        if (!tx_busy) begin
          timer_nxt_s = '0;
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_GAP: begin
        if (timer_r == GAP_LAST) begin
          timer_nxt_s = '0;
          state_nxt_s = ST_IDLE;
        end else begin
          timer_nxt_s = timer_r + TIMER_W'(1);
        end
      end
      default: begin
        tx_req_nxt_s = 1'b0;
        timer_nxt_s  = '0;
        state_nxt_s  = ST_IDLE;
      end
    endcase
  end

  // FSM state, timer, request level and the byte presented to the transmitter
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= '0;
      tx_req_r  <= 1'b0;
      tx_data_r <= '0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      tx_req_r <= tx_req_nxt_s;
      if (pop_s) begin
        tx_data_r <= rd_data_s;
      end
    end
  end

  // Sticky error flags; a new event outranks a same-cycle clear
  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end
      if (to_evt_s) begin
        timeout_err_r <= 1'b1;
      end else if (clr_err) begin
        timeout_err_r <= 1'b0;
      end
    end
  end

  assign full        = full_s;
  assign empty       = empty_s;
  assign count       = count_s;
  assign tx_req      = tx_req_r;
  assign tx_data     = tx_data_r;
  assign overflow    = overflow_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder. Accepted host bytes are pushed into a
// reference queue; a monitor pops and compares whenever a new request
// appears, and also checks acknowledge timing, inter-frame gaps and timeout
// length. A simple transmitter model answers requests when enabled.
module tb_uart_tx_feeder;

  localparam int DEPTH      = 16;
  localparam int TIMEOUT    = 1023;
  localparam int GAP_CYCLES = 4;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       drain_en;
  logic       clr_err;
  logic       tx_busy;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       tx_req;
  logic [7:0] tx_data;
  logic       overflow;
  logic       timeout_err;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic       model_ovf = 1'b0;
  logic       xmit_en   = 1'b1;

  int cyc        = 0;
  int busy_rise  = -1000;
  int last_fall  = -1000;
  int req_rise   = 0;
  logic prev_req  = 1'b0;
  logic prev_busy = 1'b0;

  always #10 clk_50M = ~clk_50M;

  uart_tx_feeder dut (
    .clk_50M     (clk_50M),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .drain_en    (drain_en),
    .clr_err     (clr_err),
    .tx_busy     (tx_busy),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .overflow    (overflow),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference FIFO: a write is judged on occupancy before the edge
  task automatic model_write(input logic [7:0] b);
    if (exp_q.size() >= DEPTH) model_ovf = 1'b1;
    else exp_q.push_back(b);
  endtask

  task automatic tick();
    @(negedge clk_50M);
    #1;
  endtask

  task automatic step();
    tick();
    wr_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b);
    tick();
    wr_en   = 1'b1;
    wr_data = b;
    model_write(b);
  endtask

  task automatic wait_quiet(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || tx_req || tx_busy) && n < budget) begin
      step();
      n++;
    end
    chk("quiet_within_budget", 32'(n < budget), 32'd1);
  endtask

  // Transmitter model: busy 3 cycles after a request, held for 20 cycles
  initial begin
    int dly  = 0;
    int hold = 0;
    tx_busy = 1'b0;
    forever begin
      @(posedge clk_50M);
      #1;
      if (!reset) begin
        tx_busy = 1'b0; dly = 0; hold = 0;
      end else if (hold > 0) begin
        hold--;
        if (hold == 0) tx_busy = 1'b0;
      end else if (tx_req && xmit_en) begin
        dly++;
        if (dly == 3) begin tx_busy = 1'b1; hold = 20; dly = 0; end
      end else begin
        dly = 0;
      end
    end
  end

  // Monitor: compare each launched byte and the request handshake timing
  initial begin
    logic [7:0] exp_b;
    forever begin
      @(negedge clk_50M);
      cyc++;
      if (!reset) begin
        prev_req = 1'b0; prev_busy = 1'b0; last_fall = -1000; busy_rise = -1000;
      end else begin
        if (tx_busy && !prev_busy) busy_rise = cyc;
        if (!tx_busy && prev_busy) last_fall = cyc;
        if (tx_req && !prev_req) begin
          req_rise = cyc;
          chk("queue_nonempty_on_req", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            exp_b = exp_q.pop_front();
            chk("tx_data", 32'(tx_data), 32'(exp_b));
          end
          chk("gap_after_frame", 32'((cyc - last_fall) >= GAP_CYCLES), 32'd1);
        end
        if (!tx_req && prev_req) begin
          if (xmit_en) begin
            chk("req_drop_after_busy", 32'(cyc - busy_rise), 32'd1);
          end else begin
            chk("timeout_len", 32'((cyc - req_rise) >= TIMEOUT && (cyc - req_rise) <= TIMEOUT + 1), 32'd1);
            chk("timeout_flag_set", 32'(timeout_err), 32'd1);
          end
        end
        prev_req  = tx_req;
        prev_busy = tx_busy;
      end
    end
  end

  initial begin
    int n;
    reset = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    drain_en = 1'b0; clr_err = 1'b0;
    repeat (3) @(negedge clk_50M);
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_tx_req", 32'(tx_req), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b1;

    // Single byte latency and handshake
    tick(); drain_en = 1'b1;
    write_byte(8'hA5);
    step();
    chk("t1_empty_after_write", 32'(empty), 32'd0);
    chk("t1_no_req_yet", 32'(tx_req), 32'd0);
    step();
    chk("t1_req_two_cycles", 32'(tx_req), 32'd1);
    chk("t1_tx_data", 32'(tx_data), 32'hA5);
    chk("t1_empty_after_pop", 32'(empty), 32'd1);
    wait_quiet(200);
    repeat (10) step();

    // Fill to full, overflow, then drain in order
    tick(); drain_en = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    write_byte(8'hFF);
    step();
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'(exp_q.size()));
    chk("t2_overflow", 32'(overflow), 32'(model_ovf));
    tick(); clr_err = 1'b1; model_ovf = 1'b0;
    step();
    chk("t2_overflow_cleared", 32'(overflow), 32'(model_ovf));
    drain_en = 1'b1;
    wait_quiet(1500);
    repeat (20) step();
    chk("t2_empty", 32'(empty), 32'd1);
    chk("t2_count_zero", 32'(count), 32'd0);

    // Unacknowledged requests time out and the next byte follows
    xmit_en = 1'b0;
    write_byte(8'($urandom));
    write_byte(8'($urandom));
    step();
    wait_quiet(3000);
    repeat (10) step();
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    chk("t3_empty", 32'(empty), 32'd1);
    tick(); clr_err = 1'b1;
    step();
    chk("t3_timeout_cleared", 32'(timeout_err), 32'd0);
    xmit_en = 1'b1;

    // Same-cycle write and pop at count 5, then flush with a write
    tick(); drain_en = 1'b0;
    for (int i = 0; i < 5; i++) write_byte(8'($urandom));
    step();
    chk("t4_count5", 32'(count), 32'd5);
    tick();
    wr_en = 1'b1; wr_data = 8'($urandom); drain_en = 1'b1;
    model_write(wr_data);
    tick();
    wr_en = 1'b0; drain_en = 1'b0;
    chk("t4_popped", 32'(tx_req), 32'd1);
    chk("t4_count_unchanged", 32'(count), 32'd5);
    tick();
    flush = 1'b1; wr_en = 1'b1; wr_data = 8'($urandom);
    exp_q.delete();
    step();
    chk("t4_flush_count", 32'(count), 32'd0);
    chk("t4_flush_empty", 32'(empty), 32'd1);
    chk("t4_flush_overflow", 32'(overflow), 32'(model_ovf));
    wait_quiet(200);
    repeat (10) step();

    // Randomized traffic with toggling drain_en
    for (int i = 0; i < 60; i++) begin
      tick();
      wr_en    = 1'($urandom % 2);
      wr_data  = 8'($urandom);
      drain_en = (($urandom % 4) != 0);
      flush    = 1'b0;
      if (wr_en) model_write(wr_data);
    end
    step();
    drain_en = 1'b1;
    wait_quiet(2500);
    repeat (10) step();
    chk("t5_overflow", 32'(overflow), 32'(model_ovf));
    chk("t5_count_zero", 32'(count), 32'd0);
    tick(); clr_err = 1'b1; model_ovf = 1'b0;
    step();

    // Reset while BUSY with three bytes still queued
    for (int i = 0; i < 4; i++) write_byte(8'($urandom));
    step();
    n = 0;
    while (!(tx_busy && !tx_req) && n < 100) begin step(); n++; end
    chk("t6_reached_busy", 32'(n < 100), 32'd1);
    chk("t6_three_queued", 32'(count), 32'd3);
    @(posedge clk_50M); #3;
    reset = 1'b0;
    exp_q.delete(); model_ovf = 1'b0;
    #1;
    chk("t6_async_tx_req", 32'(tx_req), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    chk("t6_async_empty", 32'(empty), 32'd1);
    repeat (2) tick();
    reset = 1'b1;
    repeat (80) step();
    chk("t6_no_req_after", 32'(tx_req), 32'd0);
    chk("t6_count_after", 32'(count), 32'd0);

    // Reset while REQ drops the request before the next edge
    xmit_en = 1'b0;
    write_byte(8'($urandom));
    step();
    n = 0;
    while (!tx_req && n < 20) begin step(); n++; end
    chk("t7_reached_req", 32'(tx_req), 32'd1);
    @(posedge clk_50M); #3;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("t7_async_tx_req", 32'(tx_req), 32'd0);
    repeat (2) tick();
    reset = 1'b1;
    xmit_en = 1'b1;
    repeat (20) step();
    chk("t7_idle_after", 32'(tx_req), 32'd0);
    chk("t7_no_timeout", 32'(timeout_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
Name: uart_tx_feeder

Overview:
Byte buffer and launch controller that sits directly upstream of the UART transmitter. It accepts bytes from the host side at clk_50M rate into a synchronous FIFO and holds a request-level handshake to the transmitter, which samples it on its slower baud-derived clock. It presents one byte at a time and waits for each frame to finish before issuing the next. It also reports overflow and transmitter-stall errors.

Parameters:
DEPTH, 16, FIFO entries; power of two, minimum 2
ADDR_W, 4, log2(DEPTH)
DATA_W, 8, byte width
TIMEOUT, 1023, clk_50M cycles to wait in REQ for tx_busy before abandoning the byte
GAP_CYCLES, 4, idle clk_50M cycles enforced between the end of one frame and the next request

Ports:
clk_50M  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
wr_en  in  1  host write strobe, one byte per cycle
wr_data  in  DATA_W  host byte
flush  in  1  synchronous FIFO clear
drain_en  in  1  level; permits the FSM to launch new bytes
clr_err  in  1  synchronous clear of sticky error flags
tx_busy  in  1  transmitter frame-in-progress, from the transmitter
full  out  1  FIFO full
empty  out  1  FIFO empty
count  out  ADDR_W+1  current occupancy, 0..DEPTH
tx_req  out  1  level request to the transmitter (drives its enable)
tx_data  out  DATA_W  byte for the transmitter; stable while tx_req=1 or FSM=BUSY
overflow  out  1  sticky; a write was dropped
timeout_err  out  1  sticky; the transmitter never acknowledged a request

Behaviour:
- Reset (reset=0, async): FIFO pointers and count = 0; empty=1, full=0; tx_req=0; tx_data=0; overflow=0; timeout_err=0; FSM=IDLE; timers=0.
- FIFO: wr_en && !full writes mem[wptr] and increments wptr, wrapping at DEPTH.
- Full/empty/count are registered and evaluated on the pre-edge state. A write while full is dropped and sets overflow, even if a pop occurs in the same cycle. There is no write-to-read bypass.
- Simultaneous write and pop when not full and not empty: count is unchanged; both pointers advance.
- flush: wptr=rptr=count=0 next cycle and takes priority over a same-cycle write, which is dropped without setting overflow. Flush does not affect the FSM or a byte already in tx_data.
- clr_err clears overflow and timeout_err. An error event in the same cycle wins, so the flag stays 1.
- FSM states:
  - IDLE: if drain_en && !empty, pop the head into tx_data, set tx_req=1 and go to REQ.
  - REQ: tx_req=1 and the timer counts. If tx_busy=1, set tx_req=0, clear the timer and go to BUSY. If the timer reaches TIMEOUT, set tx_req=0, set timeout_err, discard the byte and go to GAP.
  - BUSY: wait for tx_busy=0, then clear the timer and go to GAP.
  - GAP: count GAP_CYCLES cycles, then go to IDLE.
- Latency: a write at edge N gives empty=0 after edge N. The FSM pops at edge N+1 and tx_req=1 after edge N+1.
- drain_en deasserted outside IDLE does not abort the byte in flight; it only blocks the next launch.
- tx_busy already high on entry to REQ is treated as an acknowledge, which gives the BUSY transition in the next cycle.
- Mid-operation reset drops tx_req immediately (asynchronous) and discards all buffered bytes.
- All arithmetic is unsigned. Pointers are ADDR_W bits with natural wrap. count is ADDR_W+1 bits. The timer is wide enough for max(TIMEOUT, GAP_CYCLES).

Decomposition:
- Shared package uart_pkg holds DATA_W and the FSM state encoding (IDLE=2'b00, REQ=2'b01, BUSY=2'b10, GAP=2'b11).
- One sub-module, uart_sync_fifo, contains the memory, pointers, count, full/empty and overflow detection.
- uart_tx_feeder wraps uart_sync_fifo and adds the FSM, the timer and the error flags.

Test Plan:
- Reset, then write 0xA5 with drain_en=1 and a transmitter model that raises tx_busy 3 cycles after tx_req and holds it 20 cycles -> tx_req high 2 cycles after the write, tx_data=0xA5, tx_req falls the cycle after tx_busy rises, empty=1.
- Write 16 bytes 0x00..0x0F with drain_en=0, then a 17th byte 0xFF -> full=1, count=16, overflow=1. Enable draining -> bytes leave in order 0x00..0x0F, with at least GAP_CYCLES idle cycles between frames, and 0xFF is never sent.
- tx_busy held 0 with one byte queued -> after TIMEOUT cycles tx_req=0, timeout_err=1, and the FSM continues to the next byte. clr_err -> timeout_err=0.
- FIFO at count=5: same-cycle write and pop -> count stays 5. flush with wr_en=1 -> count=0, overflow unchanged.
- Drive reset=0 while in BUSY with 3 bytes queued -> tx_req=0 asynchronously, count=0. After release, FSM=IDLE and no further requests occur.
